// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and control-bundle type for the pipeline stage register.
// Imported by the interface, the stage top and the skid buffer.
package pipe_stage_reg_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NDATA_DEF  = 2;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned M_W_DEF    = 3;
    localparam int unsigned WB_W_DEF   = 2;

    typedef struct packed {
        logic [REG_W_DEF-1:0] rd;
        logic [M_W_DEF-1:0]   m;
        logic [WB_W_DEF-1:0]  wb;
    } ctrl_t;

    localparam int unsigned CTRL_W_DEF = $bits(ctrl_t);

    function automatic int unsigned entry_width(input int unsigned data_w,
                                                input int unsigned ndata,
                                                input int unsigned reg_w,
                                                input int unsigned m_w,
                                                input int unsigned wb_w);
        return data_w * ndata + reg_w + m_w + wb_w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle of the pipeline stage register.
// master = upstream/downstream environment, slave = the stage itself.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = pipe_stage_reg_pkg::DATA_W_DEF,
    parameter int unsigned NDATA  = pipe_stage_reg_pkg::NDATA_DEF,
    parameter int unsigned REG_W  = pipe_stage_reg_pkg::REG_W_DEF,
    parameter int unsigned M_W    = pipe_stage_reg_pkg::M_W_DEF,
    parameter int unsigned WB_W   = pipe_stage_reg_pkg::WB_W_DEF
);

    logic                    in_valid;
    logic                    in_ready;
    logic [NDATA*DATA_W-1:0] in_data;
    logic [REG_W-1:0]        in_reg;
    logic [M_W-1:0]          in_m;
    logic [WB_W-1:0]         in_wb;
    logic                    stall;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [NDATA*DATA_W-1:0] out_data;
    logic [REG_W-1:0]        out_reg;
    logic [M_W-1:0]          out_m;
    logic [WB_W-1:0]         out_wb;
    logic [1:0]              occ;

    modport master (
        output in_valid, in_data, in_reg, in_m, in_wb, stall, flush, out_ready,
        input  in_ready, out_valid, out_data, out_reg, out_m, out_wb, occ
    );

    modport slave (
        input  in_valid, in_data, in_reg, in_m, in_wb, stall, flush, out_ready,
        output in_ready, out_valid, out_data, out_reg, out_m, out_wb, occ
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Single skid entry behind the head of the pipeline stage; falling-edge state,
// asynchronous active-high reset.
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush and bubble masking.
// Define PIPE_SKID_EN for a 2-entry (head + skid) stage with registered in_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NDATA  = NDATA_DEF,
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned M_W    = M_W_DEF,
    parameter int unsigned WB_W   = WB_W_DEF
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);

    localparam int unsigned EntryW = entry_width(DATA_W, NDATA, REG_W, M_W, WB_W);

    typedef logic [EntryW-1:0] entry_t;

    entry_t          in_entry;
    entry_t          head_q, head_d;
    logic            head_valid_q, head_valid_d;
    logic            xfer_in, xfer_out;
    logic [M_W-1:0]  head_m;
    logic [WB_W-1:0] head_wb;

    assign in_entry = {bus.in_data, bus.in_reg, bus.in_m, bus.in_wb};
    assign xfer_in  = bus.in_valid & bus.in_ready;
    assign xfer_out = head_valid_q & bus.out_ready & ~bus.stall;

`ifdef PIPE_SKID_EN
    logic   skid_valid;
    logic   skid_load;
    logic   skid_pop;
    entry_t skid_data;

    // Skid only catches input that arrives while the head is held.
    assign skid_load = xfer_in & head_valid_q & ~xfer_out;
    assign skid_pop  = xfer_out & skid_valid;

    pipe_skid_buf #(
        .Width (EntryW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .data_i  (in_entry),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    // Depends only on the skid flop and stall, never on out_ready.
    assign bus.in_ready = ~bus.stall & ~skid_valid;
    assign bus.occ      = {1'b0, head_valid_q} + {1'b0, skid_valid};

    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (bus.flush) begin
            head_valid_d = 1'b0;
            head_d       = '0;
        end else if (!head_valid_q) begin
            if (xfer_in) begin
                head_valid_d = 1'b1;
                head_d       = in_entry;
            end
        end else if (xfer_out) begin
            if (skid_valid) begin
                head_d = skid_data;
            end else if (xfer_in) begin
                head_d = in_entry;
            end else begin
                head_valid_d = 1'b0;
            end
        end
    end
`else
    assign bus.in_ready = ~bus.stall & (~head_valid_q | bus.out_ready);
    assign bus.occ      = {1'b0, head_valid_q};

    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (bus.flush) begin
            head_valid_d = 1'b0;
            head_d       = '0;
        end else if (xfer_in) begin
            head_valid_d = 1'b1;
            head_d       = in_entry;
        end else if (xfer_out) begin
            head_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    assign {bus.out_data, bus.out_reg, head_m, head_wb} = head_q;
    assign bus.out_valid = head_valid_q;
    // Control fields read zero on an empty stage so downstream sees a bubble.
    assign bus.out_m     = head_valid_q ? head_m : '0;
    assign bus.out_wb    = head_valid_q ? head_wb : '0;

endmodule
